axi_sram_slave: RTL and testbench

- AXI slave that consumes the CPU AXI master port (arid/awid 4b, 32b data) and maps it onto a simple dual-port synchronous RAM: one read port and one write port.
- Serves as the memory endpoint below the CPU's SRAM-to-AXI bridge in simulation and FPGA tops.
- Read and write channels are fully independent FSMs.
- INCR and FIXED bursts up to 256 beats are supported, so future burst-capable caches can use the same slave.

---
 rtl/axi_sram_slave.sv | 205 ++++++++++++++++++++
 tb/tb_axi_sram_slave.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/axi_sram_slave.sv
// AXI slave mapping INCR/FIXED bursts onto a simple dual-port synchronous RAM.
// Read and write channels run as independent one-hot FSMs; one burst in flight per channel.
module axi_sram_slave #(
    parameter int ADDR_W = 16
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [3:0]        arid,
    input  logic [31:0]       araddr,
    input  logic [7:0]        arlen,
    input  logic [2:0]        arsize,
    input  logic [1:0]        arburst,
    input  logic              arvalid,
    output logic              arready,
    output logic [3:0]        rid,
    output logic [31:0]       rdata,
    output logic [1:0]        rresp,
    output logic              rlast,
    output logic              rvalid,
    input  logic              rready,
    input  logic [3:0]        awid,
    input  logic [31:0]       awaddr,
    input  logic [7:0]        awlen,
    input  logic [2:0]        awsize,
    input  logic [1:0]        awburst,
    input  logic              awvalid,
    output logic              awready,
    input  logic [31:0]       wdata,
    input  logic [3:0]        wstrb,
    input  logic              wlast,
    input  logic              wvalid,
    output logic              wready,
    output logic [3:0]        bid,
    output logic [1:0]        bresp,
    output logic              bvalid,
    input  logic              bready,
    output logic              ram_ren,
    output logic [ADDR_W-1:0] ram_raddr,
    input  logic [31:0]       ram_rdata,
    output logic [3:0]        ram_wen,
    output logic [ADDR_W-1:0] ram_waddr,
    output logic [31:0]       ram_wdata
);

    typedef enum logic [3:0] {
        R_IDLE = 4'b0001,
        R_ADDR = 4'b0010,
        R_WAIT = 4'b0100,
        R_DATA = 4'b1000
    } r_state_t;

    typedef enum logic [2:0] {
        W_IDLE = 3'b001,
        W_DATA = 3'b010,
        W_RESP = 3'b100
    } w_state_t;

    r_state_t    r_state, r_next;
    logic [3:0]  r_id;
    logic [31:0] r_addr;
    logic [7:0]  r_len;
    logic [2:0]  r_size;
    logic [1:0]  r_burst;
    logic [7:0]  r_cnt;
    logic [31:0] r_data;
    logic        r_final;

    w_state_t    w_state, w_next;
    logic [3:0]  w_id;
    logic [31:0] w_addr;
    logic [7:0]  w_len;
    logic [2:0]  w_size;
    logic [1:0]  w_burst;
    logic [7:0]  w_cnt;
    logic        w_err;
    logic        w_final;

    // FIXED holds the address; every other burst type steps by the beat size.
    function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [2:0] s,
                                              input logic [1:0] b);
        return (b == 2'b00) ? a : a + (32'd1 << s);
    endfunction

    assign r_final = (r_cnt == r_len);
    assign w_final = (w_cnt == w_len);

    // Read state register.
    always_ff @(posedge aclk) begin
        if (!aresetn) r_state <= R_IDLE;
        else          r_state <= r_next;
    end

    // Read next-state: address, RAM wait, then hold the beat until rready.
    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (arvalid) r_next = R_ADDR;
            R_ADDR:  r_next = R_WAIT;
            R_WAIT:  r_next = R_DATA;
            R_DATA:  if (rready) r_next = r_final ? R_IDLE : R_ADDR;
            default: r_next = R_IDLE;
        endcase
    end

    // Read outputs decoded from state.
    always_comb begin
        arready = (r_state == R_IDLE);
        ram_ren = (r_state == R_ADDR);
        rvalid  = (r_state == R_DATA);
        rlast   = (r_state == R_DATA) && r_final;
    end

    // Read datapath: request capture, RAM data capture, beat advance.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_id    <= '0;
            r_addr  <= '0;
            r_len   <= '0;
            r_size  <= '0;
            r_burst <= '0;
            r_cnt   <= '0;
            r_data  <= '0;
        end else begin
            if (r_state == R_IDLE && arvalid) begin
                r_id    <= arid;
                r_addr  <= araddr;
                r_len   <= arlen;
                r_size  <= arsize;
                r_burst <= arburst;
                r_cnt   <= '0;
            end
            if (r_state == R_WAIT) r_data <= ram_rdata;
            if (r_state == R_DATA && rready && !r_final) begin
                r_cnt  <= r_cnt + 8'd1;
                r_addr <= next_addr(r_addr, r_size, r_burst);
            end
        end
    end

    assign rid       = r_id;
    assign rdata     = r_data;
    assign rresp     = 2'b00;
    assign ram_raddr = r_addr[ADDR_W+1:2];

    // Write state register.
    always_ff @(posedge aclk) begin
        if (!aresetn) w_state <= W_IDLE;
        else          w_state <= w_next;
    end

    // Write next-state: the beat count alone ends the burst; wlast only flags errors.
    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:  if (awvalid) w_next = W_DATA;
            W_DATA:  if (wvalid && w_final) w_next = W_RESP;
            W_RESP:  if (bready) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    // Write outputs: each accepted W beat goes straight to the RAM port.
    always_comb begin
        awready = (w_state == W_IDLE);
        wready  = (w_state == W_DATA);
        bvalid  = (w_state == W_RESP);
        bresp   = ((w_state == W_RESP) && w_err) ? 2'b10 : 2'b00;
        ram_wen = ((w_state == W_DATA) && wvalid) ? wstrb : '0;
    end

    // Write datapath: request capture, beat advance, wlast consistency tracking.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            w_id    <= '0;
            w_addr  <= '0;
            w_len   <= '0;
            w_size  <= '0;
            w_burst <= '0;
            w_cnt   <= '0;
            w_err   <= 1'b0;
        end else begin
            if (w_state == W_IDLE && awvalid) begin
                w_id    <= awid;
                w_addr  <= awaddr;
                w_len   <= awlen;
                w_size  <= awsize;
                w_burst <= awburst;
                w_cnt   <= '0;
                w_err   <= 1'b0;
            end
            if (w_state == W_DATA && wvalid) begin
                if (wlast != w_final) w_err <= 1'b1;
                if (!w_final) begin
                    w_cnt  <= w_cnt + 8'd1;
                    w_addr <= next_addr(w_addr, w_size, w_burst);
                end
            end
        end
    end

    assign bid       = w_id;
    assign ram_waddr = w_addr[ADDR_W+1:2];
    assign ram_wdata = wdata;

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed self-checking bench for axi_sram_slave with a behavioural dual-port RAM.
module tb_axi_sram_slave;

    logic        aclk;
    logic        aresetn;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic        ram_ren;
    logic [15:0] ram_raddr;
    logic [31:0] ram_rdata;
    logic [3:0]  ram_wen;
    logic [15:0] ram_waddr;
    logic [31:0] ram_wdata;

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [31:0] mem [0:65535];

    axi_sram_slave #(.ADDR_W(16)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .ram_ren(ram_ren), .ram_raddr(ram_raddr), .ram_rdata(ram_rdata),
        .ram_wen(ram_wen), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Synchronous RAM: read data one cycle after ren, old data on same-cycle collision.
    always @(posedge aclk) begin
        if (ram_ren) ram_rdata <= mem[ram_raddr];
        for (int b = 0; b < 4; b++)
            if (ram_wen[b]) mem[ram_waddr][8*b +: 8] <= ram_wdata[8*b +: 8];
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=completion");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One AR burst with size=4 bytes; beat i expects word wa0+i*wa_step holding d0+i*d_step.
    task automatic read_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                              input logic [1:0] burst, input logic [15:0] wa0, input int unsigned wa_step,
                              input logic [31:0] d0, input int unsigned d_step, input int unsigned stall);
        arid = id; araddr = addr; arlen = len; arsize = 3'd2; arburst = burst; arvalid = 1'b1;
        #1 chk("arready_idle", arready, 1);
        step();
        arvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            #1;
            chk("ram_ren", ram_ren, 1);
            chk("ram_raddr", ram_raddr, wa0 + i * wa_step);
            chk("rvalid_addr", rvalid, 0);
            chk("arready_busy", arready, 0);
            step();
            chk("rvalid_wait", rvalid, 0);
            step();
            chk("rvalid", rvalid, 1);
            chk("rid", rid, id);
            chk("rdata", rdata, d0 + i * d_step);
            chk("rresp", rresp, 0);
            chk("rlast", rlast, (i == int'(len)) ? 1 : 0);
            if (i == 0) begin
                for (int s = 0; s < int'(stall); s++) begin
                    step();
                    chk("rvalid_stall", rvalid, 1);
                    chk("rdata_stall", rdata, d0);
                end
            end
            rready = 1'b1;
            step();
            rready = 1'b0;
        end
        #1;
        chk("rvalid_done", rvalid, 0);
        chk("arready_done", arready, 1);
    endtask

    // One AW burst; beat i carries d0+i with wlast from wlast_pat[i].
    task automatic write_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                               input logic [2:0] size, input logic [1:0] burst, input logic [31:0] d0,
                               input logic [3:0] strb, input logic [3:0] wlast_pat,
                               input logic [15:0] wa0, input int unsigned wa_step,
                               input logic [1:0] exp_bresp);
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        #1;
        chk("awready_idle", awready, 1);
        chk("wready_idle", wready, 0);
        step();
        awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            wvalid = 1'b1; wdata = d0 + i; wstrb = strb; wlast = wlast_pat[i];
            #1;
            chk("wready", wready, 1);
            chk("ram_wen", ram_wen, strb);
            chk("ram_waddr", ram_waddr, wa0 + i * wa_step);
            chk("ram_wdata", ram_wdata, d0 + i);
            chk("bvalid_early", bvalid, 0);
            step();
        end
        wvalid = 1'b0; wlast = 1'b0;
        #1;
        chk("bvalid", bvalid, 1);
        chk("bid", bid, id);
        chk("bresp", bresp, exp_bresp);
        chk("ram_wen_idle", ram_wen, 0);
        step();
        chk("bvalid_hold", bvalid, 1);
        chk("bresp_hold", bresp, exp_bresp);
        bready = 1'b1;
        step();
        bready = 1'b0;
        #1;
        chk("bvalid_done", bvalid, 0);
        chk("awready_done", awready, 1);
    endtask

    initial begin
        aresetn = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        step();
        step();
        chk("rst_arready", arready, 1);
        chk("rst_awready", awready, 1);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_wready", wready, 0);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_ram_ren", ram_ren, 0);
        chk("rst_ram_wen", ram_wen, 0);
        chk("rst_rid", rid, 0);
        chk("rst_bid", bid, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_rlast", rlast, 0);
        chk("rst_bresp", bresp, 0);
        aresetn = 1'b1;
        step();

        // Single full-word write then readback with a 5-cycle rready stall.
        write_burst(4'd1, 32'h1000, 8'd0, 3'd2, 2'b01, 32'hDEADBEEF, 4'hF, 4'b0001, 16'h0400, 0, 2'b00);
        read_burst(4'd0, 32'h1000, 8'd0, 2'b01, 16'h0400, 0, 32'hDEADBEEF, 0, 5);

        // Narrow byte write to lane 1 only.
        write_burst(4'd2, 32'h1001, 8'd0, 3'd0, 2'b01, 32'h0000AB00, 4'b0010, 4'b0001, 16'h0400, 0, 2'b00);
        read_burst(4'd0, 32'h1000, 8'd0, 2'b01, 16'h0400, 0, 32'hDEADABEF, 0, 0);

        // Fill words 0x800..0x803 with an INCR write burst, then INCR and FIXED reads.
        write_burst(4'd4, 32'h2000, 8'd3, 3'd2, 2'b01, 32'hA0000000, 4'hF, 4'b1000, 16'h0800, 1, 2'b00);
        read_burst(4'd9, 32'h2000, 8'd3, 2'b01, 16'h0800, 1, 32'hA0000000, 1, 0);
        read_burst(4'd10, 32'h2000, 8'd3, 2'b00, 16'h0800, 0, 32'hA0000000, 0, 0);

        // Early wlast on a 2-beat write with an INCR read running alongside.
        fork
            write_burst(4'd3, 32'h3000, 8'd1, 3'd2, 2'b01, 32'h11110000, 4'hF, 4'b0001, 16'h0C00, 1, 2'b10);
            read_burst(4'd5, 32'h2000, 8'd3, 2'b01, 16'h0800, 1, 32'hA0000000, 1, 0);
        join
        read_burst(4'd11, 32'h3000, 8'd1, 2'b01, 16'h0C00, 1, 32'h11110000, 1, 0);

        // Reset while beat 1 of a 3-beat read is presented.
        arid = 4'd6; araddr = 32'h2000; arlen = 8'd2; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
        step();
        arvalid = 1'b0;
        step();
        step();
        chk("mid_beat0_rdata", rdata, 32'hA0000000);
        rready = 1'b1;
        step();
        rready = 1'b0;
        step();
        step();
        chk("mid_beat1_rvalid", rvalid, 1);
        chk("mid_beat1_rdata", rdata, 32'hA0000001);
        chk("mid_beat1_rlast", rlast, 0);
        aresetn = 1'b0;
        step();
        chk("mid_rst_rvalid", rvalid, 0);
        chk("mid_rst_arready", arready, 1);
        chk("mid_rst_rid", rid, 0);
        aresetn = 1'b1;
        step();
        read_burst(4'd7, 32'h1000, 8'd0, 2'b01, 16'h0400, 0, 32'hDEADABEF, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
